// File: rtl/note_recorder_pkg.sv
// Shared widths, mode codes and FSM state encoding for the note recorder.
package note_recorder_pkg;

    localparam int OCTAVE_BITS   = 3;
    localparam int NOTE_BITS     = 3;
    localparam int LENGTH_BITS   = 3;
    localparam int REC_MODE_BITS = 2;

    localparam logic [REC_MODE_BITS-1:0] REC_IDLE = 2'd0;
    localparam logic [REC_MODE_BITS-1:0] REC_REC  = 2'd1;
    localparam logic [REC_MODE_BITS-1:0] REC_PLAY = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REC,
        ST_FETCH,
        ST_START,
        ST_ACK,
        ST_DONE
    } rec_state_e;

    function automatic logic [REC_MODE_BITS-1:0] mode_of(rec_state_e s);
        case (s)
            ST_IDLE: return REC_IDLE;
            ST_REC:  return REC_REC;
            default: return REC_PLAY;
        endcase
    endfunction

endpackage

// File: rtl/note_recorder_if.sv
// Capture-side and tone-generator-side tuple signals of the note recorder.
interface note_recorder_if
    import note_recorder_pkg::*;
#(
    parameter int OCT_W  = OCTAVE_BITS,
    parameter int NOTE_W = NOTE_BITS,
    parameter int LEN_W  = LENGTH_BITS
) ();

    logic              cap_valid;
    logic [OCT_W-1:0]  cap_octave;
    logic [NOTE_W-1:0] cap_note;
    logic [LEN_W-1:0]  cap_length;

    logic              snd_over;
    logic              snd_start;
    logic [OCT_W-1:0]  snd_octave;
    logic [NOTE_W-1:0] snd_note;
    logic [LEN_W-1:0]  snd_length;

    // master: key-capture stage plus tone generator; slave: the recorder
    modport master (
        output cap_valid, cap_octave, cap_note, cap_length, snd_over,
        input  snd_start, snd_octave, snd_note, snd_length
    );

    modport slave (
        input  cap_valid, cap_octave, cap_note, cap_length, snd_over,
        output snd_start, snd_octave, snd_note, snd_length
    );

endinterface

// File: rtl/note_recorder_ram.sv
// Single-port note buffer: synchronous write, registered read with 1-cycle latency.
module note_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int W     = 9
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Read data only changes on a read, so it doubles as the playback hold register.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/note_recorder.sv
// Record/playback buffer feeding the tone generator in free mode.
// Build option: define RECORDER_LOOP_EN to repeat playback at end-of-buffer.
//
// state    | meaning
// IDLE     | no activity, snd_* cleared
// REC      | storing each captured tuple
// FETCH    | reading slot rd_ptr
// START    | snd_start pulse, tuple presented
// ACK      | waiting for generator to go busy
// DONE     | waiting for generator to finish
module note_recorder
    import note_recorder_pkg::*;
#(
    parameter int   DEPTH  = 64,
    parameter int   OCT_W  = OCTAVE_BITS,
    parameter int   NOTE_W = NOTE_BITS,
    parameter int   LEN_W  = LENGTH_BITS,
    localparam int  CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     rec_key_i,
    input  logic                     play_key_i,
    input  logic                     stop_key_i,
    note_recorder_if.slave           bus,
    output logic [REC_MODE_BITS-1:0] mode_o,
    output logic [CNT_W-1:0]         count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int W  = OCT_W + NOTE_W + LEN_W;

    rec_state_e       state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] rd_ptr_q;
    logic             snd_start_q;
    logic             snd_vld_q;

    logic             cmd_idle;
    logic             cmd_rec;
    logic             cmd_play;
    logic             cmd_none;
    logic             cap_we;
    logic             rd_en;
    logic [CNT_W-1:0] rd_next;
    logic [AW-1:0]    ram_addr;
    logic [W-1:0]     ram_wdata;
    logic [W-1:0]     ram_rdata;

    always_comb begin
        cmd_idle = !en_i || stop_key_i;
        cmd_rec  = !cmd_idle && rec_key_i;
        cmd_play = !cmd_idle && !rec_key_i && play_key_i
                   && (state_q == ST_IDLE || state_q == ST_REC)
                   && (count_q != '0);
        cmd_none = !cmd_idle && !cmd_rec && !cmd_play;
    end

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign mode_o  = mode_of(state_q);

    // While recording the write pointer always equals count, so count addresses the write.
    assign cap_we    = cmd_none && (state_q == ST_REC) && bus.cap_valid && !full_o;
    assign rd_en     = cmd_none && (state_q == ST_FETCH);
    assign ram_addr  = rd_en ? rd_ptr_q[AW-1:0] : count_q[AW-1:0];
    assign ram_wdata = {bus.cap_octave, bus.cap_note, bus.cap_length};
    assign rd_next   = rd_ptr_q + CNT_W'(1);

    note_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (W)
    ) u_ram (
        .clk     (clk),
        .we_i    (cap_we),
        .re_i    (rd_en),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            snd_start_q <= 1'b0;
            snd_vld_q   <= 1'b0;
        end else begin
            snd_start_q <= 1'b0;
            if (cmd_idle) begin
                state_q   <= ST_IDLE;
                snd_vld_q <= 1'b0;
            end else if (cmd_rec) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                state_q  <= ST_REC;
            end else if (cmd_play) begin
                rd_ptr_q <= '0;
                state_q  <= ST_FETCH;
            end else begin
                case (state_q)
                    ST_REC: begin
                        if (cap_we) begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                    ST_FETCH: begin
                        state_q     <= ST_START;
                        snd_start_q <= 1'b1;
                        snd_vld_q   <= 1'b1;
                    end
                    ST_START: state_q <= ST_ACK;
                    ST_ACK: begin
                        if (!bus.snd_over) begin
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (bus.snd_over) begin
                            if (rd_next < count_q) begin
                                rd_ptr_q <= rd_next;
                                state_q  <= ST_FETCH;
                            end else begin
`ifdef RECORDER_LOOP_EN
                                rd_ptr_q <= '0;
                                state_q  <= ST_FETCH;
`else
                                state_q   <= ST_IDLE;
                                snd_vld_q <= 1'b0;
`endif
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.snd_start = snd_start_q;
    assign {bus.snd_octave, bus.snd_note, bus.snd_length} = snd_vld_q ? ram_rdata : '0;

endmodule
